// File: rtl/ntt_pointwise_mac_pkg.sv
// Shared constants for the Dilithium-style NTT datapath: modulus, Barrett
// constant, pipeline depth, transform length and controller state encodings.
package ntt_pointwise_mac_pkg;

    localparam int COEF_W = 24;
    localparam logic [COEF_W-1:0] Q = 24'd8380417;

    // MU = floor(2^48 / Q); with a 48-bit shift the quotient estimate is at most one short
    localparam int MU_W = 26;
    localparam logic [MU_W-1:0] MU = 26'd33587228;

    localparam int PIPE_LAT = 8;
    localparam int N = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/Barrett_reduce.sv
// Four-stage pipelined Barrett reduction of a full-width product to [0,Q).
// Fixed latency, no valid handshake; the caller tracks validity.
module Barrett_reduce
    import ntt_pointwise_mac_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] x,
    output logic [WIDTH-1:0]   r
);

    localparam int PW = 2 * WIDTH;
    localparam int TW = PW + MU_W;

    logic [MU_W-1:0]  q_est;
    logic [PW-1:0]    x_d1;
    logic [PW-1:0]    x_d2;
    logic [PW-1:0]    qm;
    logic [WIDTH-1:0] r_raw;

    // Quotient estimate, its multiple of Q, the remainder (< 2Q), then one conditional subtract
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_est <= '0;
            x_d1  <= '0;
            x_d2  <= '0;
            qm    <= '0;
            r_raw <= '0;
            r     <= '0;
        end else begin
            q_est <= MU_W'((TW'(x) * TW'(MU)) >> PW);
            x_d1  <= x;
            qm    <= PW'(q_est) * PW'(Q);
            x_d2  <= x_d1;
            r_raw <= WIDTH'(x_d2 - qm);
            r     <= (r_raw >= WIDTH'(Q)) ? (r_raw - WIDTH'(Q)) : r_raw;
        end
    end

endmodule

// File: rtl/mod_add.sv
// Combinational modular addition of two canonical residues with a single
// conditional subtract of Q.
module mod_add
    import ntt_pointwise_mac_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam int SW = WIDTH + 1;

    logic [SW-1:0] sum;
    logic [SW-1:0] q_ext;

    assign q_ext = SW'(Q);
    assign sum   = {1'b0, a} + {1'b0, b};
    assign y     = (sum >= q_ext) ? WIDTH'(sum - q_ext) : WIDTH'(sum);

endmodule

// File: rtl/mulred_pipe.sv
// Operand capture, full-width multiply and Barrett reduction, with a valid
// shift register that tracks each issued address through the pipe.
module mulred_pipe
    import ntt_pointwise_mac_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    output logic             c_rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] red
);

    localparam int VL = PIPE_LAT - 1;
    localparam int PW = 2 * WIDTH;

    logic [VL-1:0]    vld;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            prod <= '0;
        end else begin
            vld  <= {vld[VL-2:0], in_valid};
            a_q  <= a_data;
            b_q  <= b_data;
            prod <= PW'(a_q) * PW'(b_q);
        end
    end

    Barrett_reduce #(.WIDTH(WIDTH)) u_barrett (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (prod),
        .r     (red)
    );

    // The C read is requested two stages early so its RAM latency lines up with red
    assign c_rd_en   = vld[VL-3];
    assign out_valid = vld[VL-1];

endmodule

// File: rtl/ntt_pointwise_mac.sv
// Pointwise multiply (optionally accumulate) of two NTT-domain polynomials
// mod Q, streaming one coefficient per cycle from A/B RAMs into C.
module ntt_pointwise_mac
    import ntt_pointwise_mac_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              acc,
    output logic              done,
    output logic [ADDR_W-1:0] ram_a_addr,
    input  logic [WIDTH-1:0]  ram_a_rdata,
    output logic [ADDR_W-1:0] ram_b_addr,
    input  logic [WIDTH-1:0]  ram_b_rdata,
    output logic [ADDR_W-1:0] ram_c_addr_a,
    input  logic [WIDTH-1:0]  ram_c_rdata_a,
    output logic [ADDR_W-1:0] ram_c_addr_b,
    output logic              ram_c_we_b,
    output logic [WIDTH-1:0]  ram_c_wdata_b
);

    localparam int CW = ADDR_W + 1;

    state_t          state;
    logic [CW-1:0]   iss_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   wr_cnt;
    logic            acc_lat;
    logic            iss_valid;
    logic            c_rd_en;
    logic            red_valid;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] c_old;
    logic [WIDTH-1:0] sum;

    mulred_pipe #(.WIDTH(WIDTH)) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iss_valid),
        .a_data    (ram_a_rdata),
        .b_data    (ram_b_rdata),
        .c_rd_en   (c_rd_en),
        .out_valid (red_valid),
        .red       (red)
    );

    assign c_old = acc_lat ? ram_c_rdata_a : '0;

    mod_add #(.WIDTH(WIDTH)) u_add (
        .a (red),
        .b (c_old),
        .y (sum)
    );

    assign ram_b_addr = ram_a_addr;

    // Controller plus the C read/write sequencers, all driven by pipeline valid taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            done          <= 1'b0;
            acc_lat       <= 1'b0;
            iss_valid     <= 1'b0;
            iss_cnt       <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            ram_a_addr    <= '0;
            ram_c_addr_a  <= '0;
            ram_c_addr_b  <= '0;
            ram_c_we_b    <= 1'b0;
            ram_c_wdata_b <= '0;
        end else begin
            iss_valid  <= 1'b0;
            ram_c_we_b <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        acc_lat    <= acc;
                        ram_a_addr <= '0;
                        iss_valid  <= 1'b1;
                        iss_cnt    <= CW'(1);
                        rd_cnt     <= '0;
                        wr_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    ram_a_addr <= ADDR_W'(iss_cnt);
                    iss_valid  <= 1'b1;
                    iss_cnt    <= iss_cnt + CW'(1);
                    if (iss_cnt == CW'(N - 1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (wr_cnt == CW'(N)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Parking the read port at 0 keeps it off every write address once the reads end
            if (c_rd_en) begin
                ram_c_addr_a <= ADDR_W'(rd_cnt);
                rd_cnt       <= rd_cnt + CW'(1);
            end else begin
                ram_c_addr_a <= '0;
            end

            if (red_valid) begin
                ram_c_we_b    <= 1'b1;
                ram_c_addr_b  <= ADDR_W'(wr_cnt);
                ram_c_wdata_b <= sum;
                wr_cnt        <= wr_cnt + CW'(1);
            end
        end
    end

endmodule
